// File: rtl/alu_pkg.sv
// Shared widths, opcodes and operand/result types for the FIR arithmetic unit.
package alu_pkg;

    localparam int DW  = 16;      // operand width
    localparam int RW  = 2 * DW;  // result width
    localparam int NPP = DW / 2;  // radix-4 Booth partial products

    typedef logic signed [DW-1:0] operand_t;
    typedef logic signed [RW-1:0] result_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_SUB = 2'b10,
        OP_MAC = 2'b11
    } op_t;

    // Sign-extend an operand to the result width.
    function automatic result_t sext(input operand_t v);
        return {{(RW-DW){v[DW-1]}}, v};
    endfunction

endpackage

// File: rtl/alu_mult16s.sv
// Combinational signed 16x16 -> 32 multiplier: radix-4 Booth recoding of b
// into eight partial products of a, summed by a three-level adder tree.
// The full product always fits in 32 bits, so the modulo-2^32 sum is exact.
module mult16s
    import alu_pkg::*;
(
    input  operand_t a_i,
    input  operand_t b_i,
    output result_t  p_o
);

    result_t pp   [NPP];
    result_t lvl1 [NPP/2];
    result_t lvl2 [NPP/4];

    // Booth recoding: each overlapping 3-bit group of {b, 0} selects 0, +-a or +-2a.
    always_comb begin
        logic [DW:0]  b_ext;
        logic [2:0]   grp;
        result_t      a_ext;
        result_t      a_x2;
        result_t      mag;
        b_ext = {b_i, 1'b0};
        a_ext = sext(a_i);
        a_x2  = a_ext <<< 1;
        grp   = 3'b000;
        mag   = '0;
        for (int i = 0; i < NPP; i++) begin
            grp = b_ext[2*i+2 -: 3];
            case (grp)
                3'b001, 3'b010: mag = a_ext;
                3'b011:         mag = a_x2;
                3'b100:         mag = -a_x2;
                3'b101, 3'b110: mag = -a_ext;
                default:        mag = '0;
            endcase
            pp[i] = mag <<< (2 * i);
        end
    end

    // Adder tree: 8 -> 4 -> 2 -> 1.
    always_comb begin
        for (int i = 0; i < NPP/2; i++) begin
            lvl1[i] = pp[2*i] + pp[2*i+1];
        end
        for (int i = 0; i < NPP/4; i++) begin
            lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
        end
        p_o = lvl2[0] + lvl2[1];
    end

endmodule

// File: rtl/alu.sv
// Two-stage signed arithmetic unit for the FIR datapath. Stage 1 registers
// the operands and opcode; stage 2 computes ADD/SUB/MUL/MAC and registers the
// result. The result register doubles as the MAC accumulator, so any non-MAC
// op overwrites (seeds or clears) it. MAC wraps modulo 2^32.
module alu
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,     // synchronous, active low
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    op_sel,
    output logic [RW-1:0] result
);

    operand_t a_q, b_q;
    op_t      op_q;
    result_t  result_q, result_d;
    result_t  prod;

    mult16s u_mult (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    // Stage 1: capture operands and opcode; reset parks the op on ADD 0+0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else begin
            a_q  <= operand_t'(a);
            b_q  <= operand_t'(b);
            op_q <= op_t'(op_sel);
        end
    end

    // Stage 2 compute: select the operation on the stage-1 registers.
    always_comb begin
        result_d = '0;
        case (op_q)
            OP_ADD:  result_d = sext(a_q) + sext(b_q);
            OP_SUB:  result_d = sext(a_q) - sext(b_q);
            OP_MUL:  result_d = prod;
            OP_MAC:  result_d = result_q + prod;
            default: result_d = '0;
        endcase
    end

    // Stage 2 register: result / accumulator, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: reset behaviour, each opcode including corner
// operands, MAC accumulation and wrap, reset mid-MAC, and a back-to-back
// pipeline run checked against a small golden model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op_sel;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .op_sel (op_sel),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] av, input logic [15:0] bv);
        op_sel = op;
        a      = av;
        b      = bv;
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (result === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, result, exp);
        end
    endtask

    function automatic logic [31:0] golden(input logic [1:0] op,
                                           input logic [15:0] av,
                                           input logic [15:0] bv);
        logic signed [31:0] ax;
        logic signed [31:0] bx;
        ax = $signed(av);
        bx = $signed(bv);
        case (op)
            2'b00:   return ax + bx;
            2'b01:   return ax * bx;
            2'b10:   return ax - bx;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [1:0]  op;
        logic [15:0] ra, rb;

        // Reset held with a MUL pending on the inputs.
        rst = 1'b0;
        drive(2'b01, 16'd5, 16'd7);
        tick();
        check("reset_cycle1", 32'h0);
        tick();
        check("reset_cycle2", 32'h0);
        rst = 1'b1;
        tick();
        check("release_edge1", 32'h0);
        tick();
        check("release_mul_5x7", 32'd35);

        // Directed single operations, inputs held for two edges.
        drive(2'b00, 16'd100, 16'hFFFD);
        tick(); tick();
        check("add_100_m3", 32'h00000061);

        drive(2'b00, 16'h8000, 16'h8000);
        tick(); tick();
        check("add_min_min", 32'hFFFF0000);

        drive(2'b10, 16'd5, 16'd7);
        tick(); tick();
        check("sub_5_7", 32'hFFFFFFFE);
        tick();
        check("sub_held", 32'hFFFFFFFE);

        drive(2'b01, 16'd300, 16'hFFFE);
        tick(); tick();
        check("mul_300_m2", 32'hFFFFFDA8);

        drive(2'b01, 16'h8000, 16'h8000);
        tick(); tick();
        check("mul_min_min", 32'h40000000);

        drive(2'b01, 16'h7FFF, 16'h7FFF);
        tick(); tick();
        check("mul_max_max", 32'h3FFF0001);

        // MAC: seed with ADD 0+0, then accumulate 2*3 per cycle.
        drive(2'b00, 16'd0, 16'd0);
        tick(); tick();
        check("mac_seed", 32'h0);
        drive(2'b11, 16'd2, 16'd3);
        tick();
        check("mac_pre", 32'h0);
        tick();
        check("mac_acc1", 32'd6);
        tick();
        check("mac_acc2", 32'd12);
        tick();
        check("mac_acc3", 32'd18);

        // Reset pulse mid-MAC clears the accumulator and the in-flight op.
        rst = 1'b0;
        tick();
        check("mac_rst", 32'h0);
        rst = 1'b1;
        drive(2'b00, 16'd0, 16'd0);
        tick(); tick();
        check("mac_reseed", 32'h0);
        drive(2'b11, 16'd2, 16'd3);
        tick(); tick();
        check("mac_resume1", 32'd6);
        tick();
        check("mac_resume2", 32'd12);

        // MAC wraps modulo 2^32 without saturating.
        drive(2'b01, 16'h8000, 16'h8000);
        tick(); tick();
        check("wrap_seed", 32'h40000000);
        drive(2'b11, 16'h8000, 16'h8000);
        tick();
        check("wrap_pre", 32'h40000000);
        tick();
        check("wrap_acc1", 32'h80000000);
        tick();
        check("wrap_acc2", 32'hC0000000);
        tick();
        check("wrap_acc3", 32'h00000000);

        // Back-to-back pipeline: ADD, MUL, SUB rotating with random operands.
        for (int i = 0; i < 64; i++) begin
            case (i % 3)
                0:       op = 2'b00;
                1:       op = 2'b01;
                default: op = 2'b10;
            endcase
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            if (i == 10) begin
                ra = 16'h8000;
                rb = 16'h7FFF;
            end
            drive(op, ra, rb);
            exp_q.push_back(golden(op, ra, rb));
            tick();
            if (i >= 1) begin
                check("pipe", exp_q.pop_front());
            end
        end
        drive(2'b00, 16'd0, 16'd0);
        tick();
        check("pipe_last", exp_q.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
